// File: rtl/dcnt_timer.sv
// -----------------------------------------------------------------------------
// dcnt_timer
//
// Programmable down-counting timer with a prescaler, one-shot or periodic
// mode, and a sticky interrupt with an acknowledge handshake.
//
// A start loads the count value and snapshots the load value, prescale value
// and mode. While running, the count decrements once per prescaled tick (one
// tick every presc+1 cycles). A tick that finds the count already at zero is
// an expiry. In periodic mode an expiry reloads the count and the timer keeps
// running. In one-shot mode an expiry returns the timer to idle.
//
// Parameters
//   W   counter / load value width (W >= 2)
//   PW  prescaler width
//
// Ports
//   clk_i      clock; all state updates on the rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    start or restart; snapshots load_i, presc_i and mode_i
//   stop_i     abort; returns to idle (has priority over start_i)
//   mode_i     0 = one-shot, 1 = periodic
//   load_i     start / reload value
//   presc_i    prescale value P; one tick every P+1 cycles
//   irq_ack_i  clears irq_o and overrun_o
//   cnt_o      current count value
//   busy_o     high while running
//   expire_o   one-cycle pulse per expiry
//   irq_o      sticky: an expiry is pending
//   overrun_o  sticky: an expiry occurred while irq_o was already pending
// -----------------------------------------------------------------------------
module dcnt_timer #(
  parameter int W  = 16,
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          mode_i,
  input  logic [W-1:0]  load_i,
  input  logic [PW-1:0] presc_i,
  input  logic          irq_ack_i,
  output logic [W-1:0]  cnt_o,
  output logic          busy_o,
  output logic          expire_o,
  output logic          irq_o,
  output logic          overrun_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [W-1:0]  CNT_ZERO  = {W{1'b0}};
  localparam logic [PW-1:0] PCNT_ZERO = {PW{1'b0}};

  // Registered state
  logic [0:0]    state_r;
  logic [W-1:0]  cnt_r;
  logic [PW-1:0] pcnt_r;
  logic [W-1:0]  load_r;
  logic [PW-1:0] presc_r;
  logic          mode_r;
  logic          busy_r;
  logic          expire_r;
  logic          irq_r;
  logic          overrun_r;

  // Next-state values
  logic [0:0]    state_n_s;
  logic [W-1:0]  cnt_n_s;
  logic [PW-1:0] pcnt_n_s;
  logic [W-1:0]  load_n_s;
  logic [PW-1:0] presc_n_s;
  logic          mode_n_s;
  logic          irq_n_s;
  logic          overrun_n_s;

  // Event decode
  logic          tick_s;
  logic          expiry_s;
  logic          expiry_rec_s;

  // Tick and expiry decode from the current running state.
  always_comb begin
    tick_s   = (state_r == ST_RUN) && (pcnt_r == presc_r);
    expiry_s = tick_s && (cnt_r == CNT_ZERO);
    // A stop discards a coinciding expiry; a restart still records it.
    expiry_rec_s = expiry_s && !stop_i;
  end

  // Control FSM, count and prescaler next-state logic.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    pcnt_n_s  = pcnt_r;
    load_n_s  = load_r;
    presc_n_s = presc_r;
    mode_n_s  = mode_r;

    case (state_r)
      ST_IDLE: begin
        if (stop_i) begin
          state_n_s = ST_IDLE;
        end else if (start_i) begin
          state_n_s = ST_RUN;
          cnt_n_s   = load_i;
          pcnt_n_s  = PCNT_ZERO;
          load_n_s  = load_i;
          presc_n_s = presc_i;
          mode_n_s  = mode_i;
        end else begin
          state_n_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (stop_i) begin
          state_n_s = ST_IDLE;
          cnt_n_s   = CNT_ZERO;
          pcnt_n_s  = PCNT_ZERO;
        end else if (start_i) begin
          // Restart takes the count state even if an expiry coincides.
          state_n_s = ST_RUN;
          cnt_n_s   = load_i;
          pcnt_n_s  = PCNT_ZERO;
          load_n_s  = load_i;
          presc_n_s = presc_i;
          mode_n_s  = mode_i;
        end else if (tick_s) begin
          pcnt_n_s = PCNT_ZERO;
          if (cnt_r != CNT_ZERO) begin
            cnt_n_s = cnt_r - W'(1);
          end else if (mode_r) begin
            // Periodic reload: the reload value is shown immediately, so
            // there is no idle gap between periods.
            cnt_n_s = load_r;
          end else begin
            state_n_s = ST_IDLE;
            cnt_n_s   = CNT_ZERO;
          end
        end else begin
          pcnt_n_s = pcnt_r + PW'(1);
        end
      end

      default: begin
        state_n_s = ST_IDLE;
        cnt_n_s   = CNT_ZERO;
        pcnt_n_s  = PCNT_ZERO;
      end
    endcase
  end

  // Sticky interrupt and overrun flags; a set beats a same-cycle acknowledge.
  always_comb begin
    if (expiry_rec_s) begin
      irq_n_s = 1'b1;
    end else if (irq_ack_i) begin
      irq_n_s = 1'b0;
    end else begin
      irq_n_s = irq_r;
    end

    if (expiry_rec_s && irq_r && !irq_ack_i) begin
      overrun_n_s = 1'b1;
    end else if (irq_ack_i) begin
      overrun_n_s = 1'b0;
    end else begin
      overrun_n_s = overrun_r;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      pcnt_r    <= PCNT_ZERO;
      load_r    <= CNT_ZERO;
      presc_r   <= PCNT_ZERO;
      mode_r    <= 1'b0;
      busy_r    <= 1'b0;
      expire_r  <= 1'b0;
      irq_r     <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      cnt_r     <= cnt_n_s;
      pcnt_r    <= pcnt_n_s;
      load_r    <= load_n_s;
      presc_r   <= presc_n_s;
      mode_r    <= mode_n_s;
      busy_r    <= (state_n_s == ST_RUN);
      expire_r  <= expiry_rec_s;
      irq_r     <= irq_n_s;
      overrun_r <= overrun_n_s;
    end
  end

  assign cnt_o     = cnt_r;
  assign busy_o    = busy_r;
  assign expire_o  = expire_r;
  assign irq_o     = irq_r;
  assign overrun_o = overrun_r;

endmodule

// File: tb/tb_dcnt_timer.sv
// -----------------------------------------------------------------------------
// tb_dcnt_timer
//
// Self-checking bench for dcnt_timer. The reference model describes the timer
// by elapsed time since the last accepted start: with period
// T = (L+1)*(P+1), the count is L - (e mod T)/(P+1) and an expiry lands on
// every edge where e is a non-zero multiple of T. Directed scenarios come
// first, followed by randomized stimulus, all checked against the model.
// -----------------------------------------------------------------------------
module tb_dcnt_timer;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk_i;
  logic          rst_ni;
  logic          start_i;
  logic          stop_i;
  logic          mode_i;
  logic [W-1:0]  load_i;
  logic [PW-1:0] presc_i;
  logic          irq_ack_i;
  logic [W-1:0]  cnt_o;
  logic          busy_o;
  logic          expire_o;
  logic          irq_o;
  logic          overrun_o;

  int n_tests;
  int n_fail;

  // Reference model state
  bit     m_run;
  bit     m_mode;
  longint m_l;
  longint m_p;
  longint m_e;
  bit     m_exp;
  bit     m_irq;
  bit     m_ovr;

  dcnt_timer #(.W(W), .PW(PW)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .mode_i    (mode_i),
    .load_i    (load_i),
    .presc_i   (presc_i),
    .irq_ack_i (irq_ack_i),
    .cnt_o     (cnt_o),
    .busy_o    (busy_o),
    .expire_o  (expire_o),
    .irq_o     (irq_o),
    .overrun_o (overrun_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 1'b0;
    m_mode = 1'b0;
    m_l = 0;
    m_p = 0;
    m_e = 0;
    m_exp = 1'b0;
    m_irq = 1'b0;
    m_ovr = 1'b0;
  endfunction

  function automatic longint model_cnt();
    longint t;
    t = (m_l + 1) * (m_p + 1);
    if (m_run) return m_l - (m_e % t) / (m_p + 1);
    else return 0;
  endfunction

  // Advance the model by one clock edge using the inputs presented to it.
  function automatic void model_edge();
    longint t;
    bit exp_now;
    bit exp_rec;
    t = (m_l + 1) * (m_p + 1);
    exp_now = m_run && (((m_e + 1) % t) == 0);
    exp_rec = 1'b0;
    if (stop_i) begin
      m_run = 1'b0;
    end else if (start_i) begin
      exp_rec = exp_now;
      m_l = longint'(load_i);
      m_p = longint'(presc_i);
      m_mode = mode_i;
      m_e = 0;
      m_run = 1'b1;
    end else if (m_run) begin
      exp_rec = exp_now;
      m_e++;
      if (exp_now && !m_mode) m_run = 1'b0;
    end
    if (exp_rec && m_irq && !irq_ack_i) m_ovr = 1'b1;
    else if (irq_ack_i) m_ovr = 1'b0;
    if (exp_rec) m_irq = 1'b1;
    else if (irq_ack_i) m_irq = 1'b0;
    m_exp = exp_rec;
  endfunction

  task automatic compare_all();
    check("cnt", longint'(cnt_o), model_cnt());
    check("busy", longint'(busy_o), longint'(m_run));
    check("expire", longint'(expire_o), longint'(m_exp));
    check("irq", longint'(irq_o), longint'(m_irq));
    check("overrun", longint'(overrun_o), longint'(m_ovr));
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit st, input bit sp, input bit md,
                       input int ld, input int ps, input bit ak);
    start_i   = st;
    stop_i    = sp;
    mode_i    = md;
    load_i    = W'(ld);
    presc_i   = PW'(ps);
    irq_ack_i = ak;
    step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, longint'(cnt_o), 0);
    check({tag, "_busy"}, longint'(busy_o), 0);
    check({tag, "_expire"}, longint'(expire_o), 0);
    check({tag, "_irq"}, longint'(irq_o), 0);
    check({tag, "_overrun"}, longint'(overrun_o), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    start_i = 1'b0;
    stop_i = 1'b0;
    mode_i = 1'b0;
    load_i = '0;
    presc_i = '0;
    irq_ack_i = 1'b0;
    model_reset();

    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_cycles(2);

    // One-shot, L=3, P=1: expiry 8 edges after the start.
    drive(1'b1, 1'b0, 1'b0, 3, 1, 1'b0);
    check("os_load", longint'(cnt_o), 3);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, 9, 0, 1'b0);
      if (i == 6) check("os_cnt0", longint'(cnt_o), 0);
    end
    check("os_expire", longint'(expire_o), 1);
    check("os_irq", longint'(irq_o), 1);
    check("os_busy", longint'(busy_o), 0);
    idle_cycles(2);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

    // Periodic, L=2, P=0: expiries at edges 3, 6, 9; acks at 7 and 9.
    drive(1'b1, 1'b0, 1'b1, 2, 0, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      drive(1'b0, 1'b0, 1'b0, 5, 3, (e == 7) || (e == 9));
      if (e == 6) check("per_ovr", longint'(overrun_o), 1);
      if (e == 7) check("per_ack", longint'(irq_o), 0);
      if (e == 9) check("per_ack_set_wins", longint'(irq_o), 1);
    end

    // L=0, P=0 periodic: expiry every cycle, then stop keeps irq.
    drive(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      check("l0_expire", longint'(expire_o), 1);
    end
    drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    check("l0_stop_busy", longint'(busy_o), 0);
    check("l0_stop_irq", longint'(irq_o), 1);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

    // Restart: periodic L=10, restart at cnt 4 with load 7.
    drive(1'b1, 1'b0, 1'b1, 10, 0, 1'b0);
    idle_cycles(6);
    check("rs_cnt4", longint'(cnt_o), 4);
    drive(1'b1, 1'b0, 1'b1, 7, 0, 1'b0);
    check("rs_cnt7", longint'(cnt_o), 7);
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b0, 1'b0, 1, 1, i == 1);
    check("rs_expire8", longint'(expire_o), 1);
    for (int i = 1; i <= 7; i++) drive(1'b0, 1'b0, 1'b0, 1, 1, i == 1);
    drive(1'b1, 1'b0, 1'b1, 3, 0, 1'b0);
    check("rs_coinc_irq", longint'(irq_o), 1);
    check("rs_coinc_cnt", longint'(cnt_o), 3);

    // Stop together with start during RUN.
    drive(1'b1, 1'b1, 1'b1, 9, 0, 1'b0);
    check("ss_busy", longint'(busy_o), 0);
    check("ss_cnt", longint'(cnt_o), 0);

    // Reset mid-RUN with irq pending and count at 5.
    drive(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 10, 0, 1'b0);
    idle_cycles(5);
    check("rm_cnt5", longint'(cnt_o), 5);
    check("rm_irq1", longint'(irq_o), 1);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("rst_mid");
    model_reset();
    #1 rst_ni = 1'b1;
    idle_cycles(4);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit st;
      bit sp;
      bit ak;
      int ld;
      int ps;
      st = ($urandom_range(0, 19) == 0);
      sp = ($urandom_range(0, 39) == 0);
      ak = ($urandom_range(0, 7) == 0);
      ld = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 65535));
      ps = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      drive(st, sp, 1'($urandom_range(0, 1)), ld, ps, ak);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
